// File: rtl/r_pkt_tx.sv
// r_pkt_tx: packet transmitter feeding the 1x4 router input side.
// Takes a destination/length command, buffers the whole payload, then emits a
// header byte, the payload bytes and a trailing parity byte. Router err is
// collected over a short post-parity window and reported with tx_done.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   cmd_*      command handshake (addr 0..3, len 1..63; len 0 is dropped)
//   pl_*       payload byte handshake
//   busy, err  router back-pressure and parity-error indication
//   data_out   byte to router data_in
//   pkt_valid  to router pkt_valid
//   tx_done    end-of-packet pulse, tx_err qualifies it
//   tx_drop    pulse for a discarded zero-length command
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// LOAD    | pl_ready high, filling the payload buffer
// HEADER  | header byte on the bus
// PAYLOAD | buffered payload bytes on the bus
// PARITY  | parity byte on the bus, pkt_valid low
// WAIT    | err window and inter-packet gap

module r_pkt_tx #(
   parameter int unsigned ERR_WIN = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_addr,
   input  logic [5:0] cmd_len,
   input  logic [7:0] pl_data,
   input  logic       pl_valid,
   output logic       pl_ready,
   input  logic       busy,
   input  logic       err,
   output logic [7:0] data_out,
   output logic       pkt_valid,
   output logic       tx_done,
   output logic       tx_err,
   output logic       tx_drop
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY,
      S_WAIT
   } state_t;

   state_t     state;
   logic [1:0] addr_q;
   logic [5:0] len_q;
   logic [5:0] wr_idx;
   logic [5:0] rd_idx;
   logic [7:0] parity;
   logic       err_flag;
   logic [3:0] wait_cnt;
   logic [7:0] pl_buf [64];

   assign cmd_ready = (state == S_IDLE);
   assign pl_ready  = (state == S_LOAD);

   // Buffer contents need no reset; only the indices matter.
   always_ff @(posedge clk) begin
      if (state == S_LOAD && pl_valid) begin
         pl_buf[wr_idx] <= pl_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         addr_q    <= 2'd0;
         len_q     <= 6'd0;
         wr_idx    <= 6'd0;
         rd_idx    <= 6'd0;
         parity    <= 8'd0;
         err_flag  <= 1'b0;
         wait_cnt  <= 4'd0;
         data_out  <= 8'd0;
         pkt_valid <= 1'b0;
         tx_done   <= 1'b0;
         tx_err    <= 1'b0;
         tx_drop   <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         tx_drop <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  if (cmd_len == 6'd0) begin
                     tx_drop <= 1'b1;
                  end else begin
                     addr_q   <= cmd_addr;
                     len_q    <= cmd_len;
                     wr_idx   <= 6'd0;
                     rd_idx   <= 6'd0;
                     parity   <= {cmd_len, cmd_addr};
                     err_flag <= 1'b0;
                     state    <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (pl_valid) begin
                  parity <= parity ^ pl_data;
                  wr_idx <= wr_idx + 6'd1;
                  if (wr_idx == len_q - 6'd1) begin
                     data_out  <= {len_q, addr_q};
                     pkt_valid <= 1'b1;
                     state     <= S_HEADER;
                  end
               end
            end
            S_HEADER: begin
               if (!busy) begin
                  data_out <= pl_buf[0];
                  rd_idx   <= 6'd1;
                  state    <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               // rd_idx is the index of the next byte to present; reaching
               // len means the byte on the bus now is the last payload byte.
               if (!busy) begin
                  if (rd_idx == len_q) begin
                     data_out  <= parity;
                     pkt_valid <= 1'b0;
                     state     <= S_PARITY;
                  end else begin
                     data_out <= pl_buf[rd_idx];
                     rd_idx   <= rd_idx + 6'd1;
                  end
               end
            end
            S_PARITY: begin
               err_flag <= err_flag | err;
               if (!busy) begin
                  data_out <= 8'd0;
                  wait_cnt <= 4'(ERR_WIN - 1);
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Down-counter; tx_done is launched one count early so the
               // registered pulse lands in the final WAIT cycle.
               if (wait_cnt == 4'd0) begin
                  err_flag <= 1'b0;
                  state    <= S_IDLE;
               end else begin
                  err_flag <= err_flag | err;
                  wait_cnt <= wait_cnt - 4'd1;
                  if (wait_cnt == 4'd1) begin
                     tx_done <= 1'b1;
                     tx_err  <= err_flag | err;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_r_pkt_tx.sv
// Testbench for r_pkt_tx: directed vector table, hand-written corner
// sequences and randomized packets against a transaction-level model.
module tb_r_pkt_tx;

   localparam int ERR_WIN = 4;

   typedef logic [7:0] byte_q_t [$];

   typedef struct {
      logic [1:0] addr;
      logic [5:0] len;
      logic [7:0] p0;
      logic [7:0] p1;
      logic [7:0] p2;
      int         busy_at;
      int         busy_len;
      int         err_at;
      logic [7:0] exp_hdr;
      logic [7:0] exp_par;
      bit         exp_err;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_addr;
   logic [5:0] cmd_len;
   logic [7:0] pl_data;
   logic       pl_valid;
   logic       pl_ready;
   logic       busy;
   logic       err;
   logic [7:0] data_out;
   logic       pkt_valid;
   logic       tx_done;
   logic       tx_err;
   logic       tx_drop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   r_pkt_tx #(.ERR_WIN(ERR_WIN)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .pl_data   (pl_data),
      .pl_valid  (pl_valid),
      .pl_ready  (pl_ready),
      .busy      (busy),
      .err       (err),
      .data_out  (data_out),
      .pkt_valid (pkt_valid),
      .tx_done   (tx_done),
      .tx_err    (tx_err),
      .tx_drop   (tx_drop)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference parity: XOR fold of header and every payload byte.
   function automatic logic [7:0] model_parity(input logic [7:0] hdr, input byte_q_t pl);
      logic [7:0] p;
      p = hdr;
      foreach (pl[i]) p = p ^ pl[i];
      return p;
   endfunction

   // Drives one full packet and checks the bus cycle by cycle against the
   // expected beat list. busy_at/err_at/rst_at are beat / post-parity offsets
   // (-1 = unused). Starts and ends in an IDLE cycle.
   task automatic run_pkt(input logic [1:0] addr, input logic [5:0] len, input byte_q_t pl,
                          input int busy_at, input int busy_len, input int err_at,
                          input bit gaps, input bit noise, input int rst_at,
                          input logic [7:0] exp_hdr, input logic [7:0] exp_par,
                          input bit exp_err);
      byte_q_t beats;
      int      bi;
      int      busy_left;
      beats = {};
      beats.push_back(exp_hdr);
      foreach (pl[i]) beats.push_back(pl[i]);
      beats.push_back(exp_par);

      chk1("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_len   = len;
      tick();

      for (int i = 0; i < int'(len); i++) begin
         if (gaps) begin
            chk1("pl_ready_gap", pl_ready, 1'b1);
            pl_valid  = 1'b0;
            pl_data   = 8'($urandom);
            err       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_len   = 6'($urandom);
            tick();
         end
         chk1("pl_ready_load", pl_ready, 1'b1);
         chk1("cmd_ready_load", cmd_ready, 1'b0);
         chk1("pkt_valid_load", pkt_valid, 1'b0);
         pl_valid  = 1'b1;
         pl_data   = pl[i];
         err       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_len   = 6'($urandom);
         tick();
      end
      pl_valid = 1'b0;

      bi        = 0;
      busy_left = busy_len;
      while (bi < int'(len) + 2) begin
         chk8("data_out_beat", data_out, beats[bi]);
         chk1("pkt_valid_beat", pkt_valid, bi <= int'(len));
         chk1("tx_done_beat", tx_done, 1'b0);
         chk1("pl_ready_beat", pl_ready, 1'b0);
         chk1("cmd_ready_beat", cmd_ready, 1'b0);
         if (bi == rst_at) begin
            cmd_valid = 1'b0;
            busy      = 1'b0;
            err       = 1'b0;
            reset     = 1'b1;
            tick();
            reset = 1'b0;
            chk1("rst_pkt_valid", pkt_valid, 1'b0);
            chk8("rst_data_out", data_out, 8'h00);
            chk1("rst_cmd_ready", cmd_ready, 1'b1);
            chk1("rst_pl_ready", pl_ready, 1'b0);
            chk1("rst_tx_done", tx_done, 1'b0);
            for (int k = 0; k < ERR_WIN + 4; k++) begin
               tick();
               chk1("rst_no_done", tx_done, 1'b0);
               chk1("rst_no_pv", pkt_valid, 1'b0);
            end
            return;
         end
         if (bi == busy_at && busy_left > 0) begin
            busy      = 1'b1;
            busy_left = busy_left - 1;
            err       = (noise && bi <= int'(len)) ? 1'($urandom_range(0, 1)) : 1'b0;
         end else begin
            busy = 1'b0;
            if (bi == int'(len) + 1) err = (err_at == 0);
            else err = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bi++;
         end
         cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_len   = 6'($urandom);
         tick();
      end

      for (int w = 1; w <= ERR_WIN; w++) begin
         chk8("data_out_wait", data_out, 8'h00);
         chk1("pkt_valid_wait", pkt_valid, 1'b0);
         chk1("cmd_ready_wait", cmd_ready, 1'b0);
         chk1("tx_done_wait", tx_done, w == ERR_WIN);
         if (w == ERR_WIN) chk1("tx_err", tx_err, exp_err);
         err       = (err_at == w);
         busy      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_len   = 6'($urandom);
         tick();
      end
      cmd_valid = 1'b0;
      busy      = 1'b0;
      chk1("cmd_ready_post", cmd_ready, 1'b1);
      chk1("tx_done_post", tx_done, 1'b0);
      chk1("pkt_valid_post", pkt_valid, 1'b0);
      err = (err_at == ERR_WIN + 1);
      tick();
      err = 1'b0;
      chk1("tx_done_late_err", tx_done, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [8];
      byte_q_t    pl;
      logic [1:0] ra;
      logic [5:0] rl;
      int         r;
      int         rerr;
      int         rbusy;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = 2'd0;
      cmd_len   = 6'd0;
      pl_data   = 8'd0;
      pl_valid  = 1'b0;
      busy      = 1'b0;
      err       = 1'b0;
      tick();
      tick();
      chk8("reset_data_out", data_out, 8'h00);
      chk1("reset_pkt_valid", pkt_valid, 1'b0);
      chk1("reset_tx_done", tx_done, 1'b0);
      chk1("reset_tx_err", tx_err, 1'b0);
      chk1("reset_tx_drop", tx_drop, 1'b0);
      chk1("reset_pl_ready", pl_ready, 1'b0);
      chk1("reset_cmd_ready", cmd_ready, 1'b1);
      reset = 1'b0;
      tick();

      //            addr  len   p0     p1     p2    busy_at len err_at hdr    par    err
      vecs[0] = '{2'd2, 6'd3, 8'h11, 8'h22, 8'h33, -1, 0, -1, 8'h0E, 8'h0E, 1'b0};
      vecs[1] = '{2'd2, 6'd3, 8'h11, 8'h22, 8'h33,  2, 3, -1, 8'h0E, 8'h0E, 1'b0};
      vecs[2] = '{2'd1, 6'd1, 8'hA5, 8'h00, 8'h00, -1, 0, -1, 8'h05, 8'hA0, 1'b0};
      vecs[3] = '{2'd0, 6'd2, 8'hFF, 8'h01, 8'h00, -1, 0, -1, 8'h08, 8'hF6, 1'b0};
      vecs[4] = '{2'd3, 6'd2, 8'h5A, 8'hC3, 8'h00, -1, 0,  2, 8'h0B, 8'h92, 1'b1};
      vecs[5] = '{2'd2, 6'd1, 8'h00, 8'h00, 8'h00, -1, 0, -1, 8'h06, 8'h06, 1'b0};
      vecs[6] = '{2'd1, 6'd3, 8'h01, 8'h02, 8'h04,  4, 2, -1, 8'h0D, 8'h0A, 1'b0};
      vecs[7] = '{2'd0, 6'd1, 8'h80, 8'h00, 8'h00, -1, 0,  5, 8'h04, 8'h84, 1'b0};

      for (int v = 0; v < 8; v++) begin
         pl = {};
         if (vecs[v].len >= 6'd1) pl.push_back(vecs[v].p0);
         if (vecs[v].len >= 6'd2) pl.push_back(vecs[v].p1);
         if (vecs[v].len >= 6'd3) pl.push_back(vecs[v].p2);
         run_pkt(vecs[v].addr, vecs[v].len, pl, vecs[v].busy_at, vecs[v].busy_len,
                 vecs[v].err_at, 1'b0, 1'b0, -1, vecs[v].exp_hdr, vecs[v].exp_par,
                 vecs[v].exp_err);
      end

      // Zero-length command is dropped, then a len=1 packet goes out normally.
      cmd_valid = 1'b1;
      cmd_addr  = 2'd1;
      cmd_len   = 6'd0;
      tick();
      cmd_valid = 1'b0;
      chk1("drop_pulse", tx_drop, 1'b1);
      chk1("drop_cmd_ready", cmd_ready, 1'b1);
      chk1("drop_pkt_valid", pkt_valid, 1'b0);
      tick();
      chk1("drop_pulse_end", tx_drop, 1'b0);
      chk1("drop_cmd_ready2", cmd_ready, 1'b1);
      chk1("drop_pkt_valid2", pkt_valid, 1'b0);
      pl = {8'h3C};
      run_pkt(2'd1, 6'd1, pl, -1, 0, -1, 1'b0, 1'b0, -1, 8'h05, 8'h39, 1'b0);

      // Maximum length with pl_valid toggling every other cycle.
      pl = {};
      for (int i = 0; i < 63; i++) pl.push_back(8'(i * 37 + 5));
      run_pkt(2'd3, 6'd63, pl, -1, 0, -1, 1'b1, 1'b0, -1, 8'hFF,
              model_parity(8'hFF, pl), 1'b0);

      // Reset while payload byte 5 of a len=10 packet is on the bus.
      pl = {};
      for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
      run_pkt(2'd2, 6'd10, pl, -1, 0, -1, 1'b0, 1'b0, 5, {6'd10, 2'd2},
              model_parity({6'd10, 2'd2}, pl), 1'b0);
      pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_pkt(2'd0, 6'd4, pl, -1, 0, -1, 1'b0, 1'b0, -1, {6'd4, 2'd0},
              model_parity({6'd4, 2'd0}, pl), 1'b0);

      // Randomized packets with busy stalls, err timing and input noise.
      for (int n = 0; n < 25; n++) begin
         ra = 2'($urandom);
         rl = 6'($urandom_range(1, 20));
         pl = {};
         for (int i = 0; i < int'(rl); i++) pl.push_back(8'($urandom));
         rbusy = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, int'(rl) + 1));
         r = int'($urandom_range(0, ERR_WIN + 1));
         if (r < ERR_WIN) rerr = r;
         else if (r == ERR_WIN) rerr = -1;
         else rerr = ERR_WIN + 1;
         run_pkt(ra, rl, pl, rbusy, int'($urandom_range(1, 3)), rerr,
                 1'($urandom_range(0, 1)), 1'b1, -1, {rl, ra},
                 model_parity({rl, ra}, pl), (rerr >= 0 && rerr < ERR_WIN));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
